// File: rtl/rtc_wb_master_pkg.sv
// Shared definitions for the RTC Wishbone initiator.
// - RTC register-file address map (8 x 32-bit registers, 3-bit address).
// - FSM state encoding, exposed on the debug state output of the top.
// - Request source encoding used to route the result of a bus transaction.
package rtc_wb_master_pkg;

  localparam logic [2:0] RTC_CLOCK = 3'd0;
  localparam logic [2:0] TIMER     = 3'd1;
  localparam logic [2:0] STOPWATCH = 3'd2;
  localparam logic [2:0] ALARM     = 3'd3;
  localparam logic [2:0] SPEED     = 3'd4;
  localparam logic [2:0] HACK_TIME = 3'd5;
  localparam logic [2:0] HACK_HI   = 3'd6;
  localparam logic [2:0] HACK_LO   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STB  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_HOST = 2'd0,
    SRC_POLL = 2'd1,
    SRC_HACK = 2'd2
  } src_t;

endpackage

// File: rtl/rtc_wb_master_if.sv
// Wishbone bus between the initiator and the RTC register file.
//   cyc, stb, we, addr, data : initiator -> RTC (cycle, strobe, write enable,
//                              register address, write data)
//   ack, rdata               : RTC -> initiator (acknowledge, registered read
//                              data valid one cycle after the address)
interface rtc_wb_master_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] data;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output cyc, stb, we, addr, data,
    input  ack, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, data,
    output ack, rdata
  );
endinterface

// File: rtl/rtc_wb_master.sv
// Wishbone initiator for the RTC register file. Serves three requesters:
// host single read/write, periodic poll of the clock register (kept as a
// shadow time), and an atomic 3-beat burst read of the hack capture.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_cmd_*            host request (stb, we, addr, data)
//   o_cmd_busy         host request is not accepted while high
//   o_rsp_*            host completion pulse, read data (0 on writes), error
//   i_hack_req         pulse that starts the hack burst
//   o_hack_*           hack capture results, updated with o_hack_valid
//   o_time, o_time_stb shadow of clock register bits [25:0] and update pulse
//   wb                 Wishbone master modport toward the RTC
//   o_dbg_state        current FSM state
//
// Host handshake: i_cmd_stb is a request that is taken on any clock edge
// where o_cmd_busy is low; a request presented while o_cmd_busy is high is
// dropped, not queued. o_cmd_busy depends combinationally on i_hack_req so
// a simultaneous hack request visibly blocks the host in the same cycle.
module rtc_wb_master
  import rtc_wb_master_pkg::*;
#(
  parameter logic [31:0] POLL_CYCLES = 32'd100000,
  parameter logic        OPT_ACK     = 1'b0,
  parameter logic [7:0]  TIMEOUT     = 8'd16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_stb,
  input  logic                  i_cmd_we,
  input  logic [2:0]            i_cmd_addr,
  input  logic [31:0]           i_cmd_data,
  output logic                  o_cmd_busy,
  output logic                  o_rsp_stb,
  output logic [31:0]           o_rsp_data,
  output logic                  o_rsp_err,
  input  logic                  i_hack_req,
  output logic                  o_hack_valid,
  output logic [29:0]           o_hack_time,
  output logic [39:0]           o_hack_counter,
  output logic [25:0]           o_time,
  output logic                  o_time_stb,
  rtc_wb_master_if.master       wb,
  output state_t                o_dbg_state
);

  state_t      state;
  src_t        src;
  logic        cyc_q, stb_q, we_q;
  logic [2:0]  addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wait_cnt;
  logic        err_q;
  logic [1:0]  beat;
  logic        hack_pending;
  logic        poll_force;
  logic [31:0] poll_cnt;
  logic [29:0] hack_t_q;
  logic [31:0] hack_hi_q;

  logic        hack_go;
  logic        poll_due;
  logic        burst_active;
  logic        timeout_hit;
  logic        wait_done;
  logic        wait_err;
  logic [31:0] wait_data;

  assign wb.cyc      = cyc_q;
  assign wb.stb      = stb_q;
  assign wb.we       = we_q;
  assign wb.addr     = addr_q;
  assign wb.data     = wdata_q;
  assign o_dbg_state = state;

  // A hack request arriving in IDLE wins arbitration the same cycle.
  assign hack_go      = hack_pending | i_hack_req;
  assign poll_due     = ((POLL_CYCLES != 32'd0) && (poll_cnt == 32'd0)) | poll_force;
  assign burst_active = (state != ST_IDLE) && (src == SRC_HACK);
  assign o_cmd_busy   = (state != ST_IDLE) | hack_pending | i_hack_req;
  assign timeout_hit  = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};

  // Completion of the WAIT phase: fixed latency, ack, or timeout.
  always_comb begin
    wait_done = 1'b0;
    wait_err  = 1'b0;
    wait_data = 32'd0;
    if (state == ST_WAIT) begin
      if (OPT_ACK == 1'b0) begin
        wait_done = 1'b1;
        wait_data = wb.rdata;
      end else if (wb.ack) begin
        wait_done = 1'b1;
        wait_data = wb.rdata;
      end else if (timeout_hit) begin
        wait_done = 1'b1;
        wait_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      src            <= SRC_HOST;
      cyc_q          <= 1'b0;
      stb_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 3'd0;
      wdata_q        <= 32'd0;
      wait_cnt       <= 8'd0;
      err_q          <= 1'b0;
      beat           <= 2'd0;
      hack_pending   <= 1'b0;
      poll_force     <= 1'b0;
      poll_cnt       <= POLL_CYCLES;
      hack_t_q       <= 30'd0;
      hack_hi_q      <= 32'd0;
      o_rsp_stb      <= 1'b0;
      o_rsp_data     <= 32'd0;
      o_rsp_err      <= 1'b0;
      o_hack_valid   <= 1'b0;
      o_hack_time    <= 30'd0;
      o_hack_counter <= 40'd0;
      o_time         <= 26'd0;
      o_time_stb     <= 1'b0;
    end else begin
      o_rsp_stb    <= 1'b0;
      o_time_stb   <= 1'b0;
      o_hack_valid <= 1'b0;

      // Requests during a pending or running burst merge into it.
      if (i_hack_req && !hack_pending && !burst_active)
        hack_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (hack_go) begin
            src          <= SRC_HACK;
            addr_q       <= HACK_TIME;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            beat         <= 2'd0;
            hack_pending <= 1'b0;
            cyc_q        <= 1'b1;
            stb_q        <= 1'b1;
            state        <= ST_STB;
          end else if (i_cmd_stb) begin
            src     <= SRC_HOST;
            addr_q  <= i_cmd_addr;
            we_q    <= i_cmd_we;
            wdata_q <= i_cmd_we ? i_cmd_data : 32'd0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state   <= ST_STB;
            // Writing the clock register makes the shadow stale: refresh it.
            if (i_cmd_we && (i_cmd_addr == RTC_CLOCK))
              poll_force <= 1'b1;
          end else if (poll_due) begin
            src        <= SRC_POLL;
            addr_q     <= RTC_CLOCK;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            poll_force <= 1'b0;
            cyc_q      <= 1'b1;
            stb_q      <= 1'b1;
            state      <= ST_STB;
          end else if (poll_cnt != 32'd0) begin
            poll_cnt <= poll_cnt - 32'd1;
          end
        end

        ST_STB: begin
          stb_q    <= 1'b0;
          wait_cnt <= 8'd0;
          state    <= ST_WAIT;
        end

        // Address stays on the bus so the RTC's registered data stays valid.
        ST_WAIT: begin
          if (wait_done) begin
            state <= ST_DONE;
            err_q <= wait_err;
            // Keep the cycle open between burst beats.
            cyc_q <= (src == SRC_HACK) && !wait_err && (beat != 2'd2);
            case (src)
              SRC_HOST: begin
                o_rsp_stb  <= 1'b1;
                o_rsp_data <= we_q ? 32'd0 : wait_data;
                o_rsp_err  <= wait_err;
              end
              SRC_POLL: begin
                if (!wait_err) begin
                  o_time     <= wait_data[25:0];
                  o_time_stb <= 1'b1;
                end
              end
              default: begin
                if (!wait_err) begin
                  case (beat)
                    2'd0:    hack_t_q  <= wait_data[29:0];
                    2'd1:    hack_hi_q <= wait_data;
                    default: begin
                      o_hack_time    <= hack_t_q;
                      o_hack_counter <= {hack_hi_q, wait_data[31:24]};
                      o_hack_valid   <= 1'b1;
                    end
                  endcase
                end
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          if (src == SRC_POLL)
            poll_cnt <= POLL_CYCLES;
          if ((src == SRC_HACK) && !err_q && (beat != 2'd2)) begin
            beat   <= beat + 2'd1;
            addr_q <= addr_q + 3'd1;
            stb_q  <= 1'b1;
            state  <= ST_STB;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_wb_master.sv
module tb_rtc_wb_master;
  import rtc_wb_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 i_clk = ~i_clk;

  int unsigned cycle = 0;
  always @(posedge i_clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- DUT 0: fixed latency, POLL_CYCLES=10 ----------------
  logic        cmd_stb0 = 0, cmd_we0 = 0, hack_req0 = 0;
  logic [2:0]  cmd_addr0 = 0;
  logic [31:0] cmd_data0 = 0;
  logic        busy0, rsp_stb0, rsp_err0, hack_valid0, time_stb0;
  logic [31:0] rsp_data0;
  logic [29:0] hack_time0;
  logic [39:0] hack_counter0;
  logic [25:0] time0;
  state_t      state0;
  rtc_wb_master_if wb0();

  rtc_wb_master #(.POLL_CYCLES(32'd10), .OPT_ACK(1'b0), .TIMEOUT(8'd16)) dut0 (
    .i_clk(i_clk), .i_reset(rst0),
    .i_cmd_stb(cmd_stb0), .i_cmd_we(cmd_we0), .i_cmd_addr(cmd_addr0), .i_cmd_data(cmd_data0),
    .o_cmd_busy(busy0), .o_rsp_stb(rsp_stb0), .o_rsp_data(rsp_data0), .o_rsp_err(rsp_err0),
    .i_hack_req(hack_req0), .o_hack_valid(hack_valid0), .o_hack_time(hack_time0),
    .o_hack_counter(hack_counter0), .o_time(time0), .o_time_stb(time_stb0),
    .wb(wb0), .o_dbg_state(state0)
  );

  logic [31:0] mem0[8];
  logic [31:0] rdata0_q;
  always @(posedge i_clk) begin
    if (rst0) begin
      mem0[0] <= 32'h00123456; mem0[1] <= 32'h0;        mem0[2] <= 32'h00000777;
      mem0[3] <= 32'h0;        mem0[4] <= 32'd2814750;  mem0[5] <= 32'h00ABCDEF;
      mem0[6] <= 32'h11223344; mem0[7] <= 32'h55000000;
    end else if (wb0.stb && wb0.we) begin
      mem0[wb0.addr] <= wb0.data;
    end
    rdata0_q <= mem0[wb0.addr];
  end
  assign wb0.rdata = rdata0_q;
  assign wb0.ack   = 1'b0;

  // ---------------- DUT 1: ack mode, TIMEOUT=4, no polling ----------------
  logic        cmd_stb1 = 0, cmd_we1 = 0, hack_req1 = 0;
  logic [2:0]  cmd_addr1 = 0;
  logic [31:0] cmd_data1 = 0;
  logic        busy1, rsp_stb1, rsp_err1, hack_valid1, time_stb1;
  logic [31:0] rsp_data1;
  logic [29:0] hack_time1;
  logic [39:0] hack_counter1;
  logic [25:0] time1;
  state_t      state1;
  rtc_wb_master_if wb1();

  rtc_wb_master #(.POLL_CYCLES(32'd0), .OPT_ACK(1'b1), .TIMEOUT(8'd4)) dut1 (
    .i_clk(i_clk), .i_reset(rst1),
    .i_cmd_stb(cmd_stb1), .i_cmd_we(cmd_we1), .i_cmd_addr(cmd_addr1), .i_cmd_data(cmd_data1),
    .o_cmd_busy(busy1), .o_rsp_stb(rsp_stb1), .o_rsp_data(rsp_data1), .o_rsp_err(rsp_err1),
    .i_hack_req(hack_req1), .o_hack_valid(hack_valid1), .o_hack_time(hack_time1),
    .o_hack_counter(hack_counter1), .o_time(time1), .o_time_stb(time_stb1),
    .wb(wb1), .o_dbg_state(state1)
  );

  logic [31:0] mem1[8];
  logic [31:0] rdata1_q;
  logic        ack_en1 = 0;
  int          ack_dly1 = 0;
  int          wcnt1 = 0;
  always @(posedge i_clk) begin
    if (rst1) begin
      for (int i = 0; i < 8; i++) mem1[i] <= 32'hA0000000 | i;
      mem1[2] <= 32'hCAFEF00D;
    end else if (wb1.stb && wb1.we) begin
      mem1[wb1.addr] <= wb1.data;
    end
    rdata1_q <= mem1[wb1.addr];
    if (wb1.cyc && !wb1.stb) wcnt1 <= wcnt1 + 1;
    else wcnt1 <= 0;
  end
  assign wb1.rdata = rdata1_q;
  assign wb1.ack   = ack_en1 && wb1.cyc && !wb1.stb && (wcnt1 == ack_dly1);

  // ---------------- driver tasks ----------------
  task automatic host_req0(input logic we, input logic [2:0] a, input logic [31:0] d,
                           output int unsigned acc);
    int n = 0;
    @(negedge i_clk);
    while (busy0 && n < 200) begin @(negedge i_clk); n++; end
    checks++;
    if (busy0) begin errors++; $display("FAIL host_req0_busy_timeout: busy=%b expected 0", busy0); end
    acc = cycle;
    cmd_we0 = we; cmd_addr0 = a; cmd_data0 = d; cmd_stb0 = 1'b1;
    @(posedge i_clk); #1 cmd_stb0 = 1'b0;
  endtask

  task automatic host_req1(input logic we, input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge i_clk);
    while (busy1 && n < 200) begin @(negedge i_clk); n++; end
    checks++;
    if (busy1) begin errors++; $display("FAIL host_req1_busy_timeout: busy=%b expected 0", busy1); end
    cmd_we1 = we; cmd_addr1 = a; cmd_data1 = d; cmd_stb1 = 1'b1;
    @(posedge i_clk); #1 cmd_stb1 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({wb0.cyc, wb0.stb, wb0.we, wb0.addr, wb0.data} !== 38'd0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {wb0.cyc, wb0.stb, wb0.we, wb0.addr, wb0.data});
    end
    checks++;
    if ({rsp_stb0, rsp_err0, rsp_data0, busy0} !== 35'd0) begin
      errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_stb0, rsp_err0, rsp_data0, busy0});
    end
    checks++;
    if ({time0, time_stb0, hack_valid0, hack_time0, hack_counter0} !== 98'd0) begin
      errors++; $display("FAIL reset_time_hack: got %h expected 0", {time0, time_stb0, hack_valid0, hack_time0, hack_counter0});
    end
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_poll;
    int n = 0;
    int k;
    bit seen = 0;
    while (n < 30) begin
      @(posedge i_clk); n++;
      @(negedge i_clk);
      if (wb0.stb) begin seen = 1; break; end
    end
    checks++;
    if (!seen || n < 10 || n > 11) begin
      errors++; $display("FAIL poll_start: got %0d cycles expected 10..11", n);
    end
    checks++;
    if ({wb0.addr, wb0.we} !== {RTC_CLOCK, 1'b0}) begin
      errors++; $display("FAIL poll_addr: got addr=%0d we=%b expected addr=0 we=0", wb0.addr, wb0.we);
    end
    seen = 0;
    for (k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (time_stb0) begin seen = 1; break; end
    end
    checks++;
    if (!seen || time0 !== 26'h0123456) begin
      errors++; $display("FAIL poll_time: stb_seen=%b got %h expected 0123456", seen, time0);
    end
  endtask

  task automatic test_host_read;
    int unsigned acc;
    int k;
    logic [31:0] exp;
    logic [3:0] bus_at_stb;
    bit seen = 0;
    exp_q.push_back(32'd2814750);
    host_req0(1'b0, SPEED, 32'd0, acc);
    bus_at_stb = 4'hF;
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (k == 1) bus_at_stb = {wb0.stb, wb0.we, wb0.addr[1:0]} ^ {1'b0, 1'b0, 2'b00};
      if (rsp_stb0) begin seen = 1; break; end
    end
    checks++;
    if (bus_at_stb !== 4'b1000) begin
      errors++; $display("FAIL read_stb: got stb,we,addr[1:0]=%b expected 1000", bus_at_stb);
    end
    checks++;
    if (!seen || k != 3) begin
      errors++; $display("FAIL read_latency: got %0d expected 3", k);
    end
    exp = exp_q.pop_front();
    checks++;
    if (rsp_data0 !== exp || rsp_err0 !== 1'b0) begin
      errors++; $display("FAIL read_data: got %0d err=%b expected %0d err=0", rsp_data0, rsp_err0, exp);
    end
  endtask

  task automatic test_host_write;
    int unsigned acc;
    int k;
    int stb_n = 0;
    logic [31:0] exp;
    bit seen = 0;
    exp_q.push_back(32'd0);
    host_req0(1'b1, TIMER, 32'h01000130, acc);
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (wb0.stb) begin
        stb_n++;
        checks++;
        if ({wb0.we, wb0.addr, wb0.data} !== {1'b1, TIMER, 32'h01000130}) begin
          errors++; $display("FAIL write_bus: got we=%b addr=%0d data=%h expected 1 1 01000130", wb0.we, wb0.addr, wb0.data);
        end
      end
      if (rsp_stb0) begin seen = 1; break; end
    end
    checks++;
    if (!seen || stb_n != 1) begin
      errors++; $display("FAIL write_stb_count: got %0d expected 1 (rsp seen=%b)", stb_n, seen);
    end
    exp = exp_q.pop_front();
    checks++;
    if (rsp_data0 !== exp) begin
      errors++; $display("FAIL write_rsp_data: got %h expected %h", rsp_data0, exp);
    end
    checks++;
    if (time_stb0 !== 1'b0 || time0 !== 26'h0123456) begin
      errors++; $display("FAIL write_no_time: got stb=%b time=%h expected 0 0123456", time_stb0, time0);
    end
  endtask

  task automatic test_force_poll;
    int unsigned acc;
    int k;
    logic [31:0] exp;
    bit seen = 0;
    exp_q.push_back(32'd0);
    host_req0(1'b1, RTC_CLOCK, 32'h03ABCDEF, acc);
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (rsp_stb0) begin seen = 1; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || rsp_data0 !== exp) begin
      errors++; $display("FAIL force_write_rsp: seen=%b got %h expected %h", seen, rsp_data0, exp);
    end
    seen = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (time_stb0) begin seen = 1; break; end
    end
    checks++;
    if (!seen || k != 4 || time0 !== 26'h3ABCDEF) begin
      errors++; $display("FAIL force_poll: seen=%b after %0d got %h expected 4 3abcdef", seen, k, time0);
    end
  endtask

  task automatic test_hack_burst;
    int n = 0;
    int stb_n = 0, valid_n = 0, gap = 0, rsp_n = 0;
    logic [2:0] seq[3];
    logic [29:0] ht = '0;
    logic [39:0] hc = '0;
    bit started = 0, done = 0;
    seq[0] = 3'd0; seq[1] = 3'd0; seq[2] = 3'd0;
    @(negedge i_clk);
    while (busy0 && n < 100) begin @(negedge i_clk); n++; end
    hack_req0 = 1'b1;
    @(posedge i_clk); #1 hack_req0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (hack_req0) hack_req0 = 1'b0;
      if (rsp_stb0) rsp_n++;
      if (hack_valid0) begin
        valid_n++;
        if (!done) begin ht = hack_time0; hc = hack_counter0; end
        done = 1;
      end
      if (!done && !started && wb0.stb && wb0.addr == HACK_TIME) started = 1;
      if (started && !done) begin
        if (!wb0.cyc) gap++;
        if (wb0.stb) begin
          if (stb_n < 3) seq[stb_n] = wb0.addr;
          stb_n++;
          if (stb_n == 2) hack_req0 = 1'b1;  // merged into the running burst
        end
      end
    end
    checks++;
    if (!started || stb_n != 3 || {seq[0], seq[1], seq[2]} !== {HACK_TIME, HACK_HI, HACK_LO}) begin
      errors++; $display("FAIL burst_addrs: got n=%0d %0d,%0d,%0d expected 3 beats 5,6,7", stb_n, seq[0], seq[1], seq[2]);
    end
    checks++;
    if (gap != 0) begin
      errors++; $display("FAIL burst_cyc_gap: got %0d low cycles expected 0", gap);
    end
    checks++;
    if (valid_n != 1) begin
      errors++; $display("FAIL burst_valid_count: got %0d expected 1", valid_n);
    end
    checks++;
    if (ht !== 30'h00ABCDEF || hc !== 40'h1122334455) begin
      errors++; $display("FAIL burst_data: got %h %h expected 00abcdef 1122334455", ht, hc);
    end
    checks++;
    if (rsp_n != 0) begin
      errors++; $display("FAIL burst_no_rsp: got %0d host pulses expected 0", rsp_n);
    end
  endtask

  task automatic test_hack_vs_host;
    int n = 0;
    int unsigned acc;
    int valid_n = 0, rsp_n = 0, k;
    logic [2:0] first_addr = 3'd0;
    bit got_first = 0, seen = 0;
    logic [31:0] exp;
    @(negedge i_clk);
    while (busy0 && n < 100) begin @(negedge i_clk); n++; end
    hack_req0 = 1'b1;
    cmd_we0 = 1'b0; cmd_addr0 = STOPWATCH; cmd_data0 = 32'd0; cmd_stb0 = 1'b1;
    #1;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++; $display("FAIL collide_busy: got %b expected 1", busy0);
    end
    @(posedge i_clk); #1 begin hack_req0 = 1'b0; cmd_stb0 = 1'b0; end
    for (k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (wb0.stb && !got_first) begin first_addr = wb0.addr; got_first = 1; end
      if (hack_valid0) valid_n++;
      if (rsp_stb0) rsp_n++;
    end
    checks++;
    if (first_addr !== HACK_TIME || valid_n != 1 || rsp_n != 0) begin
      errors++; $display("FAIL collide_order: got first=%0d valid=%0d rsp=%0d expected 5 1 0", first_addr, valid_n, rsp_n);
    end
    exp_q.push_back(32'h00000777);
    host_req0(1'b0, STOPWATCH, 32'd0, acc);
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (rsp_stb0) begin seen = 1; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || rsp_data0 !== exp) begin
      errors++; $display("FAIL collide_retry: seen=%b got %h expected %h", seen, rsp_data0, exp);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned acc_a, acc_b;
    int k;
    bit seen;
    logic [31:0] exp;
    exp_q.push_back(32'd2814750);
    exp_q.push_back(32'h00000777);
    host_req0(1'b0, SPEED, 32'd0, acc_a);
    seen = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (rsp_stb0) begin seen = 1; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || rsp_data0 !== exp) begin
      errors++; $display("FAIL b2b_first: seen=%b got %h expected %h", seen, rsp_data0, exp);
    end
    host_req0(1'b0, STOPWATCH, 32'd0, acc_b);
    seen = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (rsp_stb0) begin seen = 1; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || rsp_data0 !== exp) begin
      errors++; $display("FAIL b2b_second: seen=%b got %h expected %h", seen, rsp_data0, exp);
    end
    checks++;
    if (acc_b - acc_a != 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles expected 4", acc_b - acc_a);
    end
  endtask

  task automatic test_ack_mode;
    int k;
    bit seen = 0;
    logic [31:0] exp;
    ack_en1 = 1'b1; ack_dly1 = 2;
    exp_q.push_back(32'hCAFEF00D);
    host_req1(1'b0, STOPWATCH, 32'd0);
    for (k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      if (rsp_stb1) begin seen = 1; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || k != 5) begin
      errors++; $display("FAIL ack_latency: got %0d expected 5", k);
    end
    checks++;
    if (rsp_data1 !== exp || rsp_err1 !== 1'b0) begin
      errors++; $display("FAIL ack_data: got %h err=%b expected %h err=0", rsp_data1, rsp_err1, exp);
    end
  endtask

  task automatic test_timeout;
    int k;
    int wait_n = 0;
    bit seen = 0;
    logic [31:0] exp;
    ack_en1 = 1'b0;
    exp_q.push_back(32'd0);
    host_req1(1'b0, ALARM, 32'd0);
    for (k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (rsp_stb1) begin seen = 1; break; end
      if (wb1.cyc && !wb1.stb) wait_n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || wait_n != 4 || wb1.cyc !== 1'b0) begin
      errors++; $display("FAIL timeout_waits: got %0d cyc=%b expected 4 cyc=0", wait_n, wb1.cyc);
    end
    checks++;
    if (rsp_err1 !== 1'b1 || rsp_data1 !== exp) begin
      errors++; $display("FAIL timeout_rsp: got err=%b data=%h expected 1 %h", rsp_err1, rsp_data1, exp);
    end
  endtask

  task automatic test_reset_mid;
    int rsp_n = 0;
    ack_en1 = 1'b0;
    host_req1(1'b0, SPEED, 32'd0);
    repeat (3) @(negedge i_clk);
    rst1 = 1'b1;
    @(negedge i_clk);
    if (rsp_stb1) rsp_n++;
    checks++;
    if ({wb1.cyc, wb1.stb, wb1.addr, rsp_stb1, rsp_err1, rsp_data1, busy1} !== 40'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0", {wb1.cyc, wb1.stb, wb1.addr, rsp_stb1, rsp_err1, rsp_data1, busy1});
    end
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (rsp_stb1) rsp_n++;
    end
    checks++;
    if (rsp_n != 0) begin
      errors++; $display("FAIL reset_mid_no_rsp: got %0d pulses expected 0", rsp_n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_poll();
    test_host_read();
    test_host_write();
    test_force_poll();
    test_hack_burst();
    test_hack_vs_host();
    test_back_to_back();
    test_ack_mode();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
